// File: rtl/prescale_counter.sv
// Programmable-modulus prescaler / scan counter with up/down, enable, clear, load and terminal pulse.
// Latency: all outputs registered; q, tc and sel reflect the controls sampled on the previous rising edge.
// Backpressure: none; en=0 holds the count, and clr/load override counting for that edge.
//
// Ports:
//   clk, rst (sync, active-low)       clock and reset
//   en, clr, load, load_val, dir      count control (priority rst > clr > load > en)
//   limit                             terminal value, period = limit+1 enabled cycles
//   q, tc, sel                        count, one-cycle wrap pulse, scan index
// Optional feature macro: PRESCALE_COUNTER_ONESHOT_EN adds input oneshot / output done.
//   With oneshot=1 the counter stops at its end value after the first wrap.
module prescale_counter #(
  parameter int BITS     = 20,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic [BITS-1:0]     load_val,
  input  logic                dir,
  input  logic [BITS-1:0]     limit,
`ifdef PRESCALE_COUNTER_ONESHOT_EN
  input  logic                oneshot,
  output logic                done,
`endif
  output logic [BITS-1:0]     q,
  output logic                tc,
  output logic [SEL_BITS-1:0] sel
);

  logic [BITS-1:0]     cnt_q, cnt_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic                tc_q, tc_d;
  logic                wrap;
  logic                stop_q, stop_d;   // oneshot completed; stays 0 when the feature is absent
  logic                oneshot_w;

`ifdef PRESCALE_COUNTER_ONESHOT_EN
  assign oneshot_w = oneshot;
`else
  assign oneshot_w = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    tc_d   = 1'b0;
    stop_d = stop_q;
    wrap   = 1'b0;

    if (clr) begin
      cnt_d  = '0;
      sel_d  = '0;
      stop_d = 1'b0;
    end else if (load) begin
      // Clamp so a loaded value never sits outside the programmed period.
      cnt_d  = (load_val > limit) ? limit : load_val;
      stop_d = 1'b0;
    end else if (en && !stop_q) begin
      if (!dir) begin
        // >= rather than == so that lowering limit below the count forces a wrap.
        if (cnt_q >= limit) begin
          wrap  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + BITS'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          wrap  = 1'b1;
          cnt_d = limit;
        end else begin
          cnt_d = cnt_q - BITS'(1);
        end
      end

      if (wrap) begin
        tc_d  = 1'b1;
        sel_d = sel_q + SEL_BITS'(1);
        if (oneshot_w) begin
          // Park at the end of the run instead of restarting it.
          cnt_d  = dir ? '0 : limit;
          stop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      tc_q   <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tc_q   <= tc_d;
      stop_q <= stop_d;
    end
  end

  assign q   = cnt_q;
  assign tc  = tc_q;
  assign sel = sel_q;
`ifdef PRESCALE_COUNTER_ONESHOT_EN
  assign done = stop_q;
`endif

endmodule

// File: tb/tb_prescale_counter.sv
// Bench for prescale_counter: directed scenarios plus randomized control traffic.
// Reference model keeps the count as an integer and the scan index as a wrap tally.
// Outputs are sampled 1 time unit after each rising edge.
module tb_prescale_counter;
  localparam int BITS = 20;
  localparam int SB   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, clr, load, dir;
  logic [BITS-1:0] load_val, limit;
  logic [BITS-1:0] q;
  logic            tc;
  logic [SB-1:0]   sel;
  logic            oneshot_m;   // oneshot request seen by the model
`ifdef PRESCALE_COUNTER_ONESHOT_EN
  logic            oneshot, done;
  assign oneshot = oneshot_m;
`endif

  prescale_counter #(.BITS(BITS), .SEL_BITS(SB)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .limit(limit),
`ifdef PRESCALE_COUNTER_ONESHOT_EN
    .oneshot(oneshot), .done(done),
`endif
    .q(q), .tc(tc), .sel(sel)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_q, m_wraps, m_tc, m_done;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Next state from the behavioural rules, using the inputs present before the edge.
  function automatic void model_step();
    int lim;
    int wrap;
    lim  = int'(limit);
    wrap = 0;
    if (!rst || clr) begin
      m_q = 0; m_wraps = 0; m_tc = 0; m_done = 0;
      return;
    end
    m_tc = 0;
    if (load) begin
      m_q    = (int'(load_val) < lim) ? int'(load_val) : lim;
      m_done = 0;
      return;
    end
    if (!en || m_done != 0) return;
    if (!dir) begin
      if (m_q >= lim) wrap = 1; else m_q = m_q + 1;
    end else begin
      if (m_q == 0) wrap = 1; else m_q = m_q - 1;
    end
    if (wrap != 0) begin
      m_tc    = 1;
      m_wraps = m_wraps + 1;
      if (oneshot_m) begin
        m_q    = dir ? 0 : lim;
        m_done = 1;
      end else begin
        m_q = dir ? lim : 0;
      end
    end
  endfunction

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".q"},   64'(q),   64'(m_q));
    chk({tag, ".tc"},  64'(tc),  64'(m_tc));
    chk({tag, ".sel"}, 64'(sel), 64'(m_wraps % (1 << SB)));
`ifdef PRESCALE_COUNTER_ONESHOT_EN
    chk({tag, ".done"}, 64'(done), 64'(m_done));
`endif
  endtask

  int exp_q[5]  = '{1, 0, 3, 2, 1};
  int exp_tc[5] = '{0, 0, 1, 0, 0};
  int tc_count;

  initial begin
    m_q = 0; m_wraps = 0; m_tc = 0; m_done = 0;
    rst = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; dir = 1'b0;
    load_val = '0; limit = 20'd4; oneshot_m = 1'b0;

    // Reset held with en high
    for (int i = 0; i < 3; i++) begin
      cyc("reset");
      chk("reset.q0", 64'(q), 64'd0);
    end
    rst = 1'b1;
    cyc("release");
    chk("release.q1", 64'(q), 64'd1);

    // Up wrap, limit 4: sel goes 1,2,3,0 over four wraps
    clr = 1'b1; cyc("upclr"); clr = 1'b0;
    for (int i = 0; i < 20; i++) cyc("upwrap");
    chk("upwrap.sel_after4", 64'(sel), 64'd0);

    // Down wrap, limit 3
    limit = 20'd3; load_val = 20'd2; load = 1'b1;
    cyc("dnload");
    chk("dnload.q2", 64'(q), 64'd2);
    load = 1'b0; dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("dnwrap");
      chk("dnwrap.qseq", 64'(q), 64'(exp_q[i]));
      chk("dnwrap.tcseq", 64'(tc), 64'(exp_tc[i]));
    end
    dir = 1'b0;

    // Load clamp to limit
    limit = 20'd5; load_val = 20'd9; load = 1'b1;
    cyc("clamp");
    chk("clamp.q5", 64'(q), 64'd5);

    // clr beats load
    clr = 1'b1;
    cyc("clrload");
    chk("clrload.q0", 64'(q), 64'd0);
    clr = 1'b0;

    // Hold with en low
    load_val = 20'd3;
    cyc("holdload");
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc("hold");
      chk("hold.q3", 64'(q), 64'd3);
    end
    en = 1'b1;

    // Limit shrink below the count
    limit = 20'd10; clr = 1'b1; cyc("shrclr"); clr = 1'b0;
    for (int i = 0; i < 7; i++) cyc("shrrun");
    chk("shrink.q7", 64'(q), 64'd7);
    limit = 20'd3;
    cyc("shrink");
    chk("shrink.q0", 64'(q), 64'd0);
    chk("shrink.tc", 64'(tc), 64'd1);

    // limit 0: tc high every cycle, sel advances each cycle
    limit = 20'd0;
    for (int i = 0; i < 6; i++) begin
      cyc("lim0");
      chk("lim0.tc", 64'(tc), 64'd1);
    end

`ifdef PRESCALE_COUNTER_ONESHOT_EN
    // Oneshot: 0,1,2 then park at 2 with a single tc pulse
    limit = 20'd2; clr = 1'b1; cyc("osclr"); clr = 1'b0;
    oneshot_m = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("oneshot");
      if (tc) tc_count++;
    end
    chk("oneshot.q2", 64'(q), 64'd2);
    chk("oneshot.done", 64'(done), 64'd1);
    chk("oneshot.tcpulses", 64'(tc_count), 64'd1);
    clr = 1'b1; cyc("osclr2"); clr = 1'b0;
    chk("oneshot.doneclr", 64'(done), 64'd0);
    chk("oneshot.qclr", 64'(q), 64'd0);
    oneshot_m = 1'b0;
`endif

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 59) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 24) == 0);
      en   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0)
        limit = ($urandom_range(0, 9) == 0) ? BITS'($urandom) : BITS'($urandom_range(0, 12));
      load_val = ($urandom_range(0, 9) == 0) ? BITS'($urandom) : BITS'($urandom_range(0, 16));
`ifdef PRESCALE_COUNTER_ONESHOT_EN
      if ($urandom_range(0, 49) == 0) oneshot_m = ~oneshot_m;
`endif
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
